// File: rtl/ppu_pkg.sv
// Shared constants for the PPU scanline double buffer and its VGA read side.
package ppu_pkg;
    localparam int          LINE_W_DEF    = 256;
    localparam int          H_LAST_DEF    = 799;
    localparam logic [5:0]  BLACK_IDX_DEF = 6'h0F;
    localparam int          PIX_W         = 6;
    localparam int          HC_W          = 10;
endpackage

// File: rtl/line_ram.sv
// Two-bank scanline store: one write port, one registered read port, no reset on contents.
module line_ram
    import ppu_pkg::*;
#(
    parameter int DEPTH = LINE_W_DEF,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);
    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_bank) mem1[wr_addr] <= wr_data;
            else         mem0[wr_addr] <= wr_data;
        end
    end

    // Read returns pre-write contents; the banks never collide by construction.
    always_ff @(posedge clk) begin
        rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
endmodule

// File: rtl/ppu_line_buffer.sv
// PPU-to-VGA scanline double buffer: bank swap at end of VGA line, overrun/underrun tracking.
module ppu_line_buffer
    import ppu_pkg::*;
#(
    parameter int         LINE_W    = LINE_W_DEF,
    parameter int         H_LAST    = H_LAST_DEF,
    parameter logic [5:0] BLACK_IDX = BLACK_IDX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [5:0] pix_idx,
    input  logic       line_end,
    input  logic [9:0] hc,
    output logic [5:0] palette_disp_idx,
    output logic       wr_bank,
    output logic       overrun,
    output logic [7:0] underrun_cnt
);
    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    logic [HC_W-1:0]  next_hc;
    logic             at_last;
    logic             swap;
    logic             wr_bank_nx;
    logic             rd_bank_nx;
    logic             pending;
    logic             pending_nx;
    logic             rd_in_win;
    logic             rd_in_win_q;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] ram_q;

    assign at_last    = (hc == HC_W'(H_LAST));
    assign next_hc    = at_last ? '0 : hc + 10'd1;
    assign swap       = at_last & pending;
    assign wr_bank_nx = wr_bank ^ swap;
    // Reads look ahead one pixel using the post-swap bank so output lines up with hc.
    assign rd_bank_nx = ~wr_bank_nx;
    assign pending_nx = (pending & ~swap) | line_end;
    assign rd_in_win  = int'(next_hc) < LINE_W;
    assign rd_addr    = next_hc[AW-1:0];
    assign wr_addr    = pix_x[AW-1:0];
    assign wr_en      = pix_valid & ~reset & (int'(pix_x) < LINE_W);

    line_ram #(
        .DEPTH (LINE_W),
        .AW    (AW)
    ) u_line_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (pix_idx),
        .rd_bank (rd_bank_nx),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank      <= 1'b0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            underrun_cnt <= 8'd0;
            rd_in_win_q  <= 1'b0;
        end else begin
            wr_bank     <= wr_bank_nx;
            pending     <= pending_nx;
            rd_in_win_q <= rd_in_win;
            if (line_end & pending & ~at_last)
                overrun <= 1'b1;
            if (at_last & ~pending & (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    // Window flag is reset, so the output reads black while RAM data is still stale.
    assign palette_disp_idx = rd_in_win_q ? ram_q : BLACK_IDX;
endmodule

// File: tb/tb_ppu_line_buffer.sv
// Scoreboard bench for ppu_line_buffer against a front/back scanline reference model.
module tb_ppu_line_buffer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_x = 8'd0;
    logic [5:0] pix_idx = 6'd0;
    logic       line_end = 1'b0;
    logic [9:0] hc = 10'd0;
    logic [5:0] palette_disp_idx;
    logic       wr_bank;
    logic       overrun;
    logic [7:0] underrun_cnt;

    ppu_line_buffer dut (
        .clk              (clk),
        .reset            (reset),
        .pix_valid        (pix_valid),
        .pix_x            (pix_x),
        .pix_idx          (pix_idx),
        .line_end         (line_end),
        .hc               (hc),
        .palette_disp_idx (palette_disp_idx),
        .wr_bank          (wr_bank),
        .overrun          (overrun),
        .underrun_cnt     (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] pdi;
        bit         pdi_known;
        bit         wr;
        bit         ovr;
        int         ucnt;
        int         hcv;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference: two whole scanlines, one being drawn by the PPU and one being shown.
    logic [5:0] line_mem [2][256];
    bit         line_def [2][256];
    bit         m_draw;
    bit         m_ready;
    bit         m_ovr;
    int         m_ucnt;
    int         hc_cur = 0;

    task automatic model_reset();
        m_draw = 1'b0; m_ready = 1'b0; m_ovr = 1'b0; m_ucnt = 0;
    endtask

    task automatic model_cycle(input bit pv, input int px, input logic [5:0] pi, input bit le);
        exp_t e;
        int nh, show;
        bit last;
        last = (hc_cur == 799);
        nh   = last ? 0 : hc_cur + 1;
        e.hcv = nh;
        if (reset) begin
            model_reset();
            e.pdi = 6'h0F; e.pdi_known = 1'b1;
        end else begin
            show = (last && m_ready) ? int'(m_draw) : int'(!m_draw);
            if (nh < 256) begin
                e.pdi = line_mem[show][nh]; e.pdi_known = line_def[show][nh];
            end else begin
                e.pdi = 6'h0F; e.pdi_known = 1'b1;
            end
            if (pv) begin
                line_mem[m_draw][px] = pi;
                line_def[m_draw][px] = 1'b1;
            end
            if (le && m_ready && !last) m_ovr = 1'b1;
            if (last) begin
                if (m_ready) begin
                    m_draw = !m_draw; m_ready = 1'b0;
                end else if (m_ucnt < 255) begin
                    m_ucnt++;
                end
            end
            if (le) m_ready = 1'b1;
        end
        e.wr = m_draw; e.ovr = m_ovr; e.ucnt = m_ucnt;
        q.push_back(e);
    endtask

    // Called at negedge: drive inputs, predict, clock, advance hc.
    task automatic step(input bit pv, input int px, input logic [5:0] pi, input bit le);
        pix_valid = pv; pix_x = 8'(px); pix_idx = pi; line_end = le; hc = 10'(hc_cur);
        model_cycle(pv, px, pi, le);
        @(posedge clk);
        hc_cur = (hc_cur == 799) ? 0 : hc_cur + 1;
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                bad = (wr_bank !== e.wr) || (overrun !== e.ovr) || (int'(underrun_cnt) != e.ucnt)
                      || (e.pdi_known && (palette_disp_idx !== e.pdi));
                if (bad) begin
                    miscompares++;
                    $display("FAIL scoreboard hc=%0d got pdi=%h wr=%b ovr=%b ucnt=%0d exp pdi=%h(known=%0b) wr=%b ovr=%b ucnt=%0d",
                             e.hcv, palette_disp_idx, wr_bank, overrun, underrun_cnt,
                             e.pdi, e.pdi_known, e.wr, e.ovr, e.ucnt);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int mode, le_at, le_at2, budget;
        bit le;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) line_def[b][i] = 1'b0;
        model_reset();
        @(negedge clk);
        step(0, 0, 6'd0, 0);
        step(0, 0, 6'd0, 0);
        reset = 1'b0;
        check_val("reset_pdi", int'(palette_disp_idx), 32'h0F);
        check_val("reset_wr_bank", int'(wr_bank), 0);

        // Ramp line: idx = x[5:0], queued at hc 300, shown on the following line.
        hc_cur = 0;
        for (int i = 0; i < 800; i++)
            step(i < 256, i & 255, 6'(i & 63), i == 300);
        for (int i = 0; i < 800; i++) begin
            step(0, 0, 6'd0, 0);
            if (i == 10) check_val("ramp_px11", int'(palette_disp_idx), 11);
            if (i == 99) check_val("ramp_px100", int'(palette_disp_idx), 100 & 63);
            if (i == 299) check_val("ramp_blank", int'(palette_disp_idx), 32'h0F);
        end

        // Random lines: none / one / two pulses / pulse coinciding with hc 799.
        for (int ln = 0; ln < 12; ln++) begin
            mode   = $urandom_range(0, 3);
            le_at  = $urandom_range(260, 790);
            le_at2 = $urandom_range(le_at + 1, 798);
            for (int i = 0; i < 800; i++) begin
                le = 1'b0;
                if (mode >= 1 && i == le_at) le = 1'b1;
                if (mode == 2 && i == le_at2) le = 1'b1;
                if (mode == 3 && i == 799 && m_ready) le = 1'b1;
                step($urandom_range(0, 1), $urandom_range(0, 255), 6'($urandom_range(0, 63)), le);
            end
        end

        // Directed double pulse then coincident pulse at hc 799.
        for (int i = 0; i < 800; i++) step(0, 0, 6'd0, i == 200 || i == 400 || i == 799);
        check_val("dbl_overrun", int'(overrun), 1);
        for (int i = 0; i < 800; i++) step(0, 0, 6'd0, 0);

        // Async reset mid-line during a write at hc 100.
        for (int i = 0; i < 100; i++) step(1, i, 6'(i), i == 50);
        pix_valid = 1'b1; pix_x = 8'd100; pix_idx = 6'h3F; hc = 10'd100;
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_pdi", int'(palette_disp_idx), 32'h0F);
        check_val("rst_wr_bank", int'(wr_bank), 0);
        check_val("rst_overrun", int'(overrun), 0);
        check_val("rst_underrun", int'(underrun_cnt), 0);
        @(negedge clk);
        hc_cur = 101;
        model_reset();
        step(1, 7, 6'h01, 0);
        step(1, 8, 6'h02, 0);
        reset = 1'b0;

        // Independent read/write of x=5 in opposite banks.
        hc_cur = 790;
        step(1, 5, 6'h11, 1);
        while (hc_cur != 0) step(0, 0, 6'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 6'd0, 0);
        step(1, 5, 6'h2A, 0);
        check_val("rw_same_addr", int'(palette_disp_idx), 32'h11);
        for (int i = 0; i < 4; i++) step(0, 0, 6'd0, 0);

        // Underrun saturation over 300 short lines.
        for (int ln = 0; ln < 300; ln++) begin
            hc_cur = 798;
            step(0, 0, 6'd0, 0);
            step(0, 0, 6'd0, 0);
        end
        check_val("underrun_sat", int'(underrun_cnt), 255);

        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain queue_left=%0d exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
